instr_mem_loader: RTL and testbench

- Instruction memory for the single-cycle MIPS core, plus a byte-serial program-load port.
- The core is the reader: it fetches combinationally by PC. This block is the writer: it assembles incoming bytes into 32-bit words and writes them sequentially from word 0.
- It holds the core in reset until a load completes, then releases it to run.

---
 rtl/instr_mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Instruction memory for the single-cycle MIPS core with a byte-serial
//   program-load port. Incoming bytes (big-endian, MSB byte first) are packed
//   into 32-bit words and written sequentially from word 0. The core is held
//   in reset (cpu_hold) until a load completes, then fetches combinationally.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   load_req      pulse: start (or restart) a program load
//   load_end      pulse: last byte of the program has been sent
//   rx_valid      rx_data holds a valid byte
//   rx_data       program byte
//   rx_ready      loader accepts a byte this cycle
//   pc            fetch address from the core
//   instr         instruction word for pc (NOP when not fetchable)
//   cpu_hold      registered; 1 keeps the core in reset
//   load_done     high while in RUN
//   load_err      sticky error flag, cleared by load_req or reset
//   words_loaded  number of words written in the current image
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for load_req; core held
// LOAD   | accepting bytes and writing words; core held
// RUN    | image complete; core released, fetches served
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              load_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] WORDS_ONE = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_q, err_d;
    logic              hold_q;

    logic [31:0]       mem [DEPTH];

    logic              full;
    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_hit;
    logic              unused_pc;

    assign full   = (words_q == FULL_CNT);
    assign accept = rx_valid && rx_ready;
    // A restart on the same edge drops the in-flight byte, including a 4th one.
    assign wr_en  = accept && (byte_cnt_q == 2'd3) && !load_req;

    // ---------------------------------------------------------------
    // State register (plus registered hold and datapath registers)
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            words_q    <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            words_q    <= words_d;
            err_q      <= err_d;
            // Falls on the same edge that enters RUN so the core's PC starts at 0.
            hold_q     <= (state_d != S_RUN);
        end
    end

    // Memory array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[words_q[ADDR_W-1:0]] <= {shift_q, rx_data};
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (load_req) state_d = S_LOAD;
            S_LOAD: begin
                if (load_req)      state_d = S_LOAD;
                else if (load_end) state_d = S_RUN;
            end
            S_RUN:  if (load_req) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        words_d    = words_q;
        err_d      = err_q;
        if (load_req) begin
            byte_cnt_d = 2'd0;
            shift_d    = 24'd0;
            words_d    = '0;
            err_d      = 1'b0;
        end else if (state_q == S_LOAD) begin
            if (accept) begin
                shift_d    = {shift_q[15:0], rx_data};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    words_d = words_q + WORDS_ONE;
                end
            end
            if (rx_valid && full) begin
                err_d = 1'b1;
            end
            // Checked against the post-accept count so a final byte landing
            // together with load_end completes its word cleanly.
            if (load_end) begin
                if (byte_cnt_d != 2'd0) begin
                    err_d = 1'b1;
                end
                byte_cnt_d = 2'd0;
                shift_d    = 24'd0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    assign fetch_idx = pc[ADDR_W+1:2];
    assign unused_pc = ^pc[1:0];

    always_comb begin
        rx_ready  = 1'b0;
        load_done = 1'b0;
        fetch_hit = 1'b0;
        instr     = 32'h0000_0000;
        case (state_q)
            S_LOAD: rx_ready = !full;
            S_RUN: begin
                load_done = 1'b1;
                fetch_hit = (pc[31:ADDR_W+2] == '0) && ({1'b0, fetch_idx} < words_q);
                if (fetch_hit) begin
                    instr = mem[fetch_idx];
                end
            end
            default: ;
        endcase
    end

    assign cpu_hold     = hold_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    logic        clk;
    logic        reset;
    logic        load_req;
    logic        load_end;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] pc;

    logic        rx_ready,  s_rx_ready;
    logic [31:0] instr,     s_instr;
    logic        cpu_hold,  s_cpu_hold;
    logic        load_done, s_load_done;
    logic        load_err,  s_load_err;
    logic [6:0]  words_loaded;
    logic [2:0]  s_words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    instr_mem_loader #(.DEPTH(64), .ADDR_W(6)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .load_end     (load_end),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .pc           (pc),
        .instr        (instr),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    instr_mem_loader #(.DEPTH(4), .ADDR_W(2)) u_small (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .load_end     (load_end),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (s_rx_ready),
        .pc           (pc),
        .instr        (s_instr),
        .cpu_hold     (s_cpu_hold),
        .load_done    (s_load_done),
        .load_err     (s_load_err),
        .words_loaded (s_words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic fetch_big(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        check(tag, instr, exp);
    endtask

    task automatic fetch_small(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        check(tag, s_instr, exp);
    endtask

    logic [7:0]  prog_a [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    logic [31:0] full_words [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};

    initial begin
        reset    = 1'b1;
        load_req = 1'b0;
        load_end = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 32'h0;
        #2;
        check("rst_hold",  {31'd0, cpu_hold},  32'd1);
        check("rst_words", {25'd0, words_loaded}, 32'd0);
        check("rst_ready", {31'd0, rx_ready},  32'd0);
        check("rst_done",  {31'd0, load_done}, 32'd0);
        check("rst_err",   {31'd0, load_err},  32'd0);
        check("rst_instr", instr, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_ready", {31'd0, rx_ready}, 32'd0);

        // Normal load
        pulse_req();
        check("load_ready", {31'd0, rx_ready}, 32'd1);
        check("load_instr", instr, 32'h0);
        for (int i = 0; i < 8; i++) send_byte(prog_a[i]);
        check("norm_words_pre", {25'd0, words_loaded}, 32'd2);
        check("norm_hold_pre",  {31'd0, cpu_hold}, 32'd1);
        pulse_end();
        check("norm_done",  {31'd0, load_done}, 32'd1);
        check("norm_hold",  {31'd0, cpu_hold},  32'd0);
        check("norm_err",   {31'd0, load_err},  32'd0);
        check("norm_words", {25'd0, words_loaded}, 32'd2);
        check("norm_ready", {31'd0, rx_ready}, 32'd0);
        fetch_big("norm_pc0",    32'h0,    32'h20080005);
        fetch_big("norm_pc4",    32'h4,    32'h20090007);
        fetch_big("norm_pc5",    32'h5,    32'h20090007);
        fetch_big("norm_pc8",    32'h8,    32'h0);
        fetch_big("norm_pc1000", 32'h1000, 32'h0);

        // Backpressure: valid every other cycle
        pulse_req();
        for (int i = 0; i < 8; i++) begin
            send_byte(prog_a[7 - i]);
            tick();
            if (i == 2) check("bp_words_3b", {25'd0, words_loaded}, 32'd0);
            if (i == 3) check("bp_words_4b", {25'd0, words_loaded}, 32'd1);
        end
        pulse_end();
        check("bp_err", {31'd0, load_err}, 32'd0);
        fetch_big("bp_pc0", 32'h0, 32'h07000920);
        fetch_big("bp_pc4", 32'h4, 32'h05000820);

        // Partial word
        pulse_req();
        for (int i = 0; i < 6; i++) send_byte(8'h11 * (i + 1));
        pulse_end();
        check("part_words", {25'd0, words_loaded}, 32'd1);
        check("part_err",   {31'd0, load_err},  32'd1);
        check("part_done",  {31'd0, load_done}, 32'd1);
        fetch_big("part_pc0", 32'h0, 32'h11223344);
        fetch_big("part_pc4", 32'h4, 32'h0);

        // Full on the DEPTH=4 instance
        pulse_req();
        check("full_err_clr", {31'd0, s_load_err}, 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("full_ready", {31'd0, s_rx_ready}, 32'd0);
        check("full_words", {29'd0, s_words_loaded}, 32'd4);
        check("full_err0",  {31'd0, s_load_err}, 32'd0);
        send_byte(8'hFF);
        check("full_err1",  {31'd0, s_load_err}, 32'd1);
        check("full_stay",  {31'd0, s_load_done}, 32'd0);
        for (int i = 0; i < 3; i++) send_byte(8'hEE);
        check("full_words2", {29'd0, s_words_loaded}, 32'd4);
        pulse_end();
        check("full_done", {31'd0, s_load_done}, 32'd1);
        for (int i = 0; i < 4; i++) fetch_small($sformatf("full_mem%0d", i), 32'(i * 4), full_words[i]);

        // Reload from RUN
        pulse_req();
        check("rl_hold",  {31'd0, cpu_hold},  32'd1);
        check("rl_done",  {31'd0, load_done}, 32'd0);
        check("rl_err",   {31'd0, s_load_err}, 32'd0);
        fetch_big("rl_instr", 32'h0, 32'h0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        pulse_end();
        fetch_big("rl_pc0", 32'h0, 32'hAABBCCDD);
        fetch_big("rl_pc4", 32'h4, 32'h0);

        // Last byte coincident with load_end; load_req beats load_end
        pulse_req();
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA);
        load_end = 1'b1;
        send_byte(8'hBE);
        load_end = 1'b0;
        check("coin_err",   {31'd0, load_err}, 32'd0);
        check("coin_words", {25'd0, words_loaded}, 32'd1);
        fetch_big("coin_pc0", 32'h0, 32'hCAFEBABE);
        pulse_req();
        load_req = 1'b1;
        load_end = 1'b1;
        tick();
        load_req = 1'b0;
        load_end = 1'b0;
        check("prio_done",  {31'd0, load_done}, 32'd0);
        check("prio_ready", {31'd0, rx_ready},  32'd1);

        // Async reset mid-word
        send_byte(8'h12); send_byte(8'h34);
        #2;
        reset = 1'b1;
        #1;
        check("ar_hold",  {31'd0, cpu_hold},  32'd1);
        check("ar_words", {25'd0, words_loaded}, 32'd0);
        check("ar_ready", {31'd0, rx_ready},  32'd0);
        check("ar_done",  {31'd0, load_done}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h99);
        check("ar_noacc", {25'd0, words_loaded}, 32'd0);
        check("ar_idle_ready", {31'd0, rx_ready}, 32'd0);
        pulse_req();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        pulse_end();
        check("ar_words2", {25'd0, words_loaded}, 32'd1);
        fetch_big("ar_pc0", 32'h0, 32'h01020304);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
